inv_mix_columns_seq: RTL and testbench
======================================

INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the byte width of each state element; only 8 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port ip_matrix, input, 4x4 x DATA_WIDTH, indexed [row][col], the AES state to transform.
REQ-005 SHALL have port in_valid, input, 1, ip_matrix holds a valid state.
REQ-006 SHALL have port in_ready, output, 1, the block can accept a state.
REQ-007 SHALL have port out_matrix, output, 4x4 x DATA_WIDTH, indexed [row][col], the InvMixColumns result; it feeds the downstream inv-shift-rows stage.
REQ-008 SHALL have port out_valid, output, 1, out_matrix holds a completed result.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts out_matrix.
REQ-010 SHALL have port busy, output, 1, high whenever the state machine is not IDLE.

Function
REQ-011 SHALL implement states IDLE, CALC and DONE, plus a 2-bit column counter col.
REQ-012 SHALL drive in_ready = 1 only in IDLE with rst low.
REQ-013 SHALL perform an accept on any rising edge where in_valid and in_ready are both 1, as follows:
- Latch all 16 bytes of ip_matrix.
- Set col = 0.
- Enter CALC.
REQ-014 SHALL ignore ip_matrix and in_valid at all times other than an accept edge.
REQ-015 SHALL, on each CALC edge, process exactly one column c = col:
- Compute from the latched bytes a0..a3 = latched[0..3][c].
- Write results to result[0..3][c].
- Increment col.
REQ-016 SHALL compute each column with the following equations (GF(2^8) arithmetic):
- r0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
- r1 = 09*a0 ^ 0e*a1 ^ 0b*a2 ^ 0d*a3
- r2 = 0d*a0 ^ 09*a1 ^ 0e*a2 ^ 0b*a3
- r3 = 0b*a0 ^ 0d*a1 ^ 09*a2 ^ 0e*a3
REQ-017 SHALL use multiplication modulo x^8+x^4+x^3+x+1 (0x11B), implemented as xtime chains with no lookup tables; addition is XOR.
REQ-018 SHALL, on the CALC edge with col == 3, write column 3, wrap col to 0 and enter DONE.
REQ-019 SHALL set the latency as follows: out_valid rises after the 4th rising edge following the accept edge.
REQ-020 SHALL drive out_valid = 1 only in DONE.
REQ-021 SHALL hold out_matrix stable while out_valid = 1 and out_ready = 0, for any number of cycles.
REQ-022 SHALL, on an edge in DONE with out_ready = 1, complete the transfer and return to IDLE.
REQ-023 SHALL accept no new state on the transfer edge (in_ready is 0 in DONE); minimum spacing between accepts is 6 cycles.
REQ-024 SHALL keep out_matrix at its last value after a transfer until column 0 of the next operation is written.
REQ-025 SHALL treat out_ready asserted outside DONE as a no-op.
REQ-026 SHALL treat in_valid asserted outside IDLE as a no-op; no queuing.
REQ-027 SHALL NOT change out_matrix, out_valid or state in response to an in_valid/ip_matrix change during CALC.

Reset
REQ-028 SHALL, while rst = 1, force the following regardless of clk:
- state = IDLE and col = 0.
- All out_matrix bytes and latched bytes = 0.
- out_valid = 0, busy = 0, in_ready = 0.
REQ-029 SHALL abort any in-progress operation when rst asserts mid-CALC or in DONE; no out_valid is produced for that operation.
REQ-030 SHALL drive in_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-031 SHALL cover a single vector, expecting out_valid exactly 4 edges after the accept edge:
- Stimulus: columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6 (each as rows 0..3).
- Expected result columns: db135345, f20a225c, 01010101, c6c6c6c6.
REQ-032 SHALL cover a second vector with a one-cycle out_ready:
- Stimulus: columns d5d5d7d6, 4d7ebdf8, 00000000, ffffffff.
- Expected result columns: d4d4d4d5, 2d26314c, 00000000, ffffffff.
REQ-033 SHALL cover backpressure: hold out_ready = 0 for 10 cycles after out_valid -> out_valid stays 1, out_matrix unchanged, in_ready stays 0; then out_ready = 1 for one cycle -> IDLE and in_ready = 1 next cycle.
REQ-034 SHALL cover input noise: toggle ip_matrix and hold in_valid = 1 throughout CALC -> result equals the transform of the state latched on the accept edge only.
REQ-035 SHALL cover mid-operation reset: assert rst on the 2nd CALC cycle -> out_valid never rises, out_matrix = 0, busy = 0; a fresh accept after release then produces the correct result.
REQ-036 SHALL cover an identity round-trip: 100 random states passed through a reference MixColumns and then this block -> out_matrix equals the original state.

Source files
------------

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: latches a 4x4 state and transforms one column per clock.
// The result is held on out_matrix under a valid/ready handshake until the downstream stage takes it.
module inv_mix_columns_seq #(
  parameter int DATA_WIDTH = 8  // only 8-bit bytes are meaningful for AES
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [3:0][3:0][DATA_WIDTH-1:0]      ip_matrix,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [3:0][3:0][DATA_WIDTH-1:0]      out_matrix,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                            state;
  logic [1:0]                        col;
  logic [3:0][3:0][DATA_WIDTH-1:0]   latched;
  logic [3:0][DATA_WIDTH-1:0]        col_in;
  logic [3:0][DATA_WIDTH-1:0]        col_out;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [DATA_WIDTH-1:0] xtime(input logic [DATA_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] shifted;
    shifted = {a[DATA_WIDTH-2:0], 1'b0};
    return a[DATA_WIDTH-1] ? (shifted ^ DATA_WIDTH'(8'h1b)) : shifted;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mul_09(input logic [DATA_WIDTH-1:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mul_0b(input logic [DATA_WIDTH-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mul_0d(input logic [DATA_WIDTH-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mul_0e(input logic [DATA_WIDTH-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Only the column currently selected by col feeds the shared multiplier network.
  always_comb begin
    col_in  = '0;
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      col_in[r] = latched[r][col];
    end
    col_out[0] = mul_0e(col_in[0]) ^ mul_0b(col_in[1]) ^ mul_0d(col_in[2]) ^ mul_09(col_in[3]);
    col_out[1] = mul_09(col_in[0]) ^ mul_0e(col_in[1]) ^ mul_0b(col_in[2]) ^ mul_0d(col_in[3]);
    col_out[2] = mul_0d(col_in[0]) ^ mul_09(col_in[1]) ^ mul_0e(col_in[2]) ^ mul_0b(col_in[3]);
    col_out[3] = mul_0b(col_in[0]) ^ mul_0d(col_in[1]) ^ mul_09(col_in[2]) ^ mul_0e(col_in[3]);
  end

  // out_matrix is only written in CALC, so it keeps the previous result until column 0 is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= 2'd0;
      latched    <= '0;
      out_matrix <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            latched <= ip_matrix;
            col     <= 2'd0;
            state   <= CALC;
          end
        end
        CALC: begin
          for (int r = 0; r < 4; r++) begin
            out_matrix[r][col] <= col_out[r];
          end
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          col   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq: expected results are queued at issue time
// and popped by a monitor whenever the DUT hands a result downstream.
module tb_inv_mix_columns_seq;

  typedef logic [3:0][3:0][7:0] mat_t;

  logic clk = 1'b0;
  logic rst;
  mat_t ip_matrix;
  logic in_valid;
  logic in_ready;
  mat_t out_matrix;
  logic out_valid;
  logic out_ready;
  logic busy;

  int   assertions = 0;
  int   failures   = 0;
  mat_t exp_q[$];

  inv_mix_columns_seq #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ip_matrix  (ip_matrix),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_matrix (out_matrix),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Plain shift-and-add field multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p;
    int aa;
    p  = 0;
    aa = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
    end
    return p[7:0];
  endfunction

  // Circulant column mix; k holds the first matrix row as bytes k0..k3.
  function automatic mat_t mix_by(input mat_t s, input logic [31:0] k);
    mat_t r;
    logic [7:0] coef;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        for (int j = 0; j < 4; j++) begin
          coef = k[31 - 8*((j - row) & 3) -: 8];
          r[row][c] = r[row][c] ^ gmul(coef, s[j][c]);
        end
      end
    end
    return r;
  endfunction

  function automatic mat_t from_cols(input logic [31:0] c0, input logic [31:0] c1,
                                     input logic [31:0] c2, input logic [31:0] c3);
    mat_t m;
    logic [31:0] cw [4];
    cw[0] = c0; cw[1] = c1; cw[2] = c2; cw[3] = c3;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        m[r][c] = cw[c][31 - 8*r -: 8];
      end
    end
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        m[r][c] = 8'($urandom);
      end
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge when both valid and ready are high.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        checkOutput("scoreboard", out_matrix, exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input mat_t m, input mat_t exp, input int hold, input bit noise);
    int   n;
    mat_t held;
    @(posedge clk); #1;
    checkOutput("in_ready_idle", in_ready, 1);
    ip_matrix = m;
    in_valid  = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    if (!noise) in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (noise) ip_matrix = rand_mat();
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    checkOutput("latency", n, 4);
    held = out_matrix;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", {out_valid, in_ready}, 2'b10);
      checkOutput("hold_matrix", out_matrix, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("idle_after_xfer", {in_ready, busy, out_valid}, 3'b100);
    checkOutput("matrix_after_xfer", out_matrix, held);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mat_t s;
    mat_t m;
    bit   seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ip_matrix = '0;
    #12;
    checkOutput("reset_matrix", out_matrix, 0);
    checkOutput("reset_flags", {out_valid, busy, in_ready}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", in_ready, 1);

    applyStimulus(from_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6),
                  from_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6), 0, 1'b0);
    applyStimulus(from_cols(32'hd5d5d7d6, 32'h4d7ebdf8, 32'h00000000, 32'hffffffff),
                  from_cols(32'hd4d4d4d5, 32'h2d26314c, 32'h00000000, 32'hffffffff), 0, 1'b0);

    m = rand_mat();
    applyStimulus(m, mix_by(m, 32'h0e0b0d09), 10, 1'b0);
    m = rand_mat();
    applyStimulus(m, mix_by(m, 32'h0e0b0d09), 0, 1'b1);

    // Abort on the second CALC cycle.
    @(posedge clk); #1;
    ip_matrix = rand_mat();
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_matrix", out_matrix, 0);
    checkOutput("abort_flags", {out_valid, busy, in_ready}, 3'b000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_abort", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("no_valid_after_abort", seen, 0);
    m = rand_mat();
    applyStimulus(m, mix_by(m, 32'h0e0b0d09), 0, 1'b0);

    for (int t = 0; t < 100; t++) begin
      s = rand_mat();
      applyStimulus(mix_by(s, 32'h02030101), s, 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
